// File: rtl/ifetch_pc_pkg.sv
// Shared definitions for the instruction-fetch PC sequencer: FSM states,
// reset/NOP constants and address alignment.
package ifetch_pc_pkg;

    typedef enum logic [1:0] {
        IF_BOOT,
        IF_REQ,
        IF_WAIT,
        IF_HOLD
    } if_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_ADDI         = 32'h0000_0013;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/ifetch_pc.sv
// PC register and fetch sequencer: one outstanding imem request, a 1-entry
// instruction buffer presented to decode, and flush with response kill.
module ifetch_pc
    import ifetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = NOP_ADDI
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] npc,
    input  logic        advance,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);

    if_state_e   state_q, state_d;
    logic [31:0] fetch_q, fetch_d;
    logic [31:0] redir_q, redir_d;
    logic        kill_q, kill_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [31:0] flush_al;
    logic [31:0] npc_al;

    assign flush_al = word_align(flush_pc);
    assign npc_al   = word_align(npc);

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= IF_BOOT;
            fetch_q <= word_align(RESET_PC);
            redir_q <= word_align(RESET_PC);
            kill_q  <= 1'b0;
            pc_q    <= word_align(RESET_PC);
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            redir_q <= redir_d;
            kill_q  <= kill_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        redir_d = redir_q;
        kill_d  = kill_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;

        if (flush) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            unique case (state_q)
                IF_BOOT, IF_HOLD: begin
                    fetch_d = flush_al;
                    state_d = IF_REQ;
                end
                IF_REQ: begin
                    kill_d = 1'b1;
                    if (imem_gnt) begin
                        fetch_d = flush_al;
                        state_d = IF_WAIT;
                    end else begin
                        // Bus address must stay put until grant; park the target.
                        redir_d = flush_al;
                    end
                end
                IF_WAIT: begin
                    fetch_d = flush_al;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = IF_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: state_d = IF_BOOT;
            endcase
        end else begin
            unique case (state_q)
                IF_BOOT: state_d = IF_REQ;
                IF_REQ: begin
                    if (imem_gnt) begin
                        state_d = IF_WAIT;
                        if (kill_q) fetch_d = redir_q;
                    end
                end
                IF_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = IF_REQ;
                        end else begin
                            inst_d  = imem_rdata;
                            pc_d    = fetch_q;
                            valid_d = 1'b1;
                            state_d = IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (advance && valid_q) begin
                        fetch_d = npc_al;
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                        state_d = IF_REQ;
                    end
                end
                default: state_d = IF_BOOT;
            endcase
        end
    end

    assign imem_req   = (state_q == IF_REQ);
    assign imem_addr  = fetch_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_ifetch_pc.sv
// Directed self-checking bench for ifetch_pc: reset, sequential fetch, slow
// memory, flush in each state, flush+advance, misaligned npc, reset mid-fetch.
module tb_ifetch_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hBAAD_F00D;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] npc = '0;
    logic        advance = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_pc #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .npc        (npc),
        .advance    (advance),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    // Starts in REQ for addr; grant after gnt_wait stall cycles, response rsp_wait cycles after grant.
    task automatic do_fetch(input int gnt_wait, input int rsp_wait,
                            input logic [31:0] data, input logic [31:0] addr);
        for (int i = 0; i < gnt_wait; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== addr) begin
                n_fail++;
                $display("FAIL fetch_stall_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
            end
            tick();
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            n_fail++;
            $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < rsp_wait - 1; i++) begin
            n_checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_wait: req=%b valid=%b, expected req=0 valid=0", imem_req, inst_valid);
            end
            tick();
        end
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pre_rvalid: valid=%b, expected 0", inst_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        n_checks++;
        if (inst_valid !== 1'b1 || pc !== addr || inst !== data || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold: valid=%b pc=%h inst=%h req=%b, expected valid=1 pc=%h inst=%h req=0",
                     inst_valid, pc, inst, imem_req, addr, data);
        end
    endtask

    task automatic do_advance(input logic [31:0] npc_v, input logic [31:0] exp_addr);
        advance = 1'b1;
        npc     = npc_v;
        tick();
        advance = 1'b0;
        npc     = 32'hFFFF_FFF0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr || inst_valid !== 1'b0 || inst !== NOP) begin
            n_fail++;
            $display("FAIL advance: req=%b addr=%h valid=%b inst=%h, expected req=1 addr=%h valid=0 inst=%h",
                     imem_req, imem_addr, inst_valid, inst, exp_addr, NOP);
        end
    endtask

    task automatic test_reset;
        cpu_rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h, expected 0/0/%h/0",
                     imem_req, inst_valid, inst, pc, NOP);
        end
        cpu_rst = 1'b0;
        tick();
        do_fetch(0, 1, 32'h0050_0093, 32'h0);
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h0050_0093) begin
                n_fail++;
                $display("FAIL hold_stable: valid=%b pc=%h inst=%h, expected 1/0/00500093", inst_valid, pc, inst);
            end
        end
        do_advance(32'h4, 32'h4);
        do_fetch(0, 1, 32'h0010_0113, 32'h4);
        do_advance(32'h8, 32'h8);
        do_fetch(0, 1, 32'h0020_0193, 32'h8);
    endtask

    task automatic test_slow_memory;
        do_advance(32'hC, 32'hC);
        do_fetch(4, 3, 32'h0030_0213, 32'hC);
    endtask

    task automatic test_flush_wait;
        do_advance(32'h8, 32'h8);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h1C;
        tick();
        flush = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wait_stay: req=%b valid=%b, expected 0/0", imem_req, inst_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = BAD;
        tick();
        imem_rvalid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1C || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wait_drop: req=%b addr=%h valid=%b, expected 1/0000001c/0", imem_req, imem_addr, inst_valid);
        end
        do_fetch(0, 1, 32'h0040_0293, 32'h1C);
    endtask

    task automatic test_flush_req;
        do_advance(32'h20, 32'h20);
        flush    = 1'b1;
        flush_pc = 32'h33;
        tick();
        flush_pc = 32'h50;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL flush_req_stable1: req=%b addr=%h, expected 1/00000020", imem_req, imem_addr);
        end
        tick();
        flush = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL flush_req_stable2: req=%b addr=%h, expected 1/00000020", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = BAD;
        tick();
        imem_rvalid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h50 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req_drop: req=%b addr=%h valid=%b, expected 1/00000050/0", imem_req, imem_addr, inst_valid);
        end
        do_fetch(0, 1, 32'h0050_0313, 32'h50);
    endtask

    task automatic test_flush_wait_rvalid;
        do_advance(32'h54, 32'h54);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        flush       = 1'b1;
        flush_pc    = 32'h62;
        imem_rvalid = 1'b1;
        imem_rdata  = BAD;
        tick();
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h60 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rvalid_same: req=%b addr=%h valid=%b, expected 1/00000060/0", imem_req, imem_addr, inst_valid);
        end
        do_fetch(0, 2, 32'h0060_0393, 32'h60);
    endtask

    task automatic test_flush_advance;
        advance  = 1'b1;
        npc      = 32'h40;
        flush    = 1'b1;
        flush_pc = 32'h80;
        tick();
        advance = 1'b0;
        flush   = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || inst_valid !== 1'b0 || inst !== NOP) begin
            n_fail++;
            $display("FAIL flush_advance: req=%b addr=%h valid=%b inst=%h, expected 1/00000080/0/%h",
                     imem_req, imem_addr, inst_valid, inst, NOP);
        end
        do_fetch(0, 1, 32'h0070_0413, 32'h80);
    endtask

    task automatic test_misaligned_reset;
        do_advance(32'h0000_0106, 32'h0000_0104);
        do_fetch(1, 1, 32'h0080_0493, 32'h104);
        do_advance(32'h108, 32'h108);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        cpu_rst  = 1'b1;
        tick();
        cpu_rst = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0 || inst !== NOP) begin
            n_fail++;
            $display("FAIL reset_in_wait: req=%b valid=%b pc=%h inst=%h, expected 0/0/0/%h",
                     imem_req, inst_valid, pc, inst, NOP);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = BAD;
        tick();
        imem_rvalid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== NOP) begin
            n_fail++;
            $display("FAIL late_rvalid: req=%b addr=%h valid=%b inst=%h, expected 1/0/0/%h",
                     imem_req, imem_addr, inst_valid, inst, NOP);
        end
        do_fetch(0, 1, 32'h0090_0513, 32'h0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_slow_memory();
        test_flush_wait();
        test_flush_req();
        test_flush_wait_rvalid();
        test_flush_advance();
        test_misaligned_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
